// File: rtl/display_select_ctrl.sv
// Key/switch front end for the debug display multiplexer: synchronises and debounces
// the pushbuttons, steps a wrapping select index and opens a timed display-enable preview.
module display_select_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] PREVIEW_CYCLES  = 24'd12500000,
    parameter logic [4:0]  MAX_SELECT      = 5'd18
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KEY_Next,
    input  logic       KEY_Prev,
    input  logic       KEY_Show,
    input  logic [4:0] SW_Direct,
    input  logic       SW_DirectEn,
    output logic [4:0] Display_Select,
    output logic       Display_Enable,
    output logic       Select_Changed
);

    localparam int unsigned NUM_KEYS = 3;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned PRE_W    = 24;
    localparam int unsigned SEL_W    = 5;

    // Key bit order: 0 = Next, 1 = Prev, 2 = Show
    logic [NUM_KEYS-1:0]            key_raw;
    logic [NUM_KEYS-1:0]            sync_a;
    logic [NUM_KEYS-1:0]            sync_b;
    logic [NUM_KEYS-1:0]            stable;
    logic [1:0]                     stable_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] db_cnt;
    logic [SEL_W-1:0]               sw_q;
    logic                           sw_en_q;
    logic [PRE_W-1:0]               preview;
    logic [1:0]                     press;
    logic [SEL_W-1:0]               sel_next;
    logic                           changed;

    assign key_raw = {KEY_Show, KEY_Prev, KEY_Next};

    // Press events fire only on the released -> pressed edge of the debounced state
    assign press = stable_d & ~stable[1:0];

    always_comb begin
        sel_next = Display_Select;
        if (sw_en_q) begin
            if (sw_q <= MAX_SELECT) begin
                sel_next = sw_q;
            end
        end else if (press[0] && press[1]) begin
            sel_next = Display_Select;
        end else if (press[0]) begin
            sel_next = (Display_Select == MAX_SELECT) ? SEL_W'(0) : Display_Select + SEL_W'(1);
        end else if (press[1]) begin
            sel_next = (Display_Select == SEL_W'(0)) ? MAX_SELECT : Display_Select - SEL_W'(1);
        end
    end

    assign changed = (sel_next != Display_Select);

    // Synchronisers and per-key debounce counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_a   <= '1;
            sync_b   <= '1;
            stable   <= '1;
            stable_d <= '1;
            db_cnt   <= '0;
            sw_q     <= '0;
            sw_en_q  <= 1'b0;
        end else begin
            sync_a   <= key_raw;
            sync_b   <= sync_a;
            stable_d <= stable[1:0];
            sw_q     <= SW_Direct;
            sw_en_q  <= SW_DirectEn;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync_b[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - CNT_W'(1)) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Select index, change pulse, preview window and display enable
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Display_Select <= '0;
            Select_Changed <= 1'b0;
            Display_Enable <= 1'b0;
            preview        <= '0;
        end else begin
            Display_Select <= sel_next;
            Select_Changed <= changed;
            Display_Enable <= ~stable[2] | (preview != PRE_W'(0)) | changed;
            if (changed) begin
                preview <= PREVIEW_CYCLES;
            end else if (preview != PRE_W'(0)) begin
                preview <= preview - PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_select_ctrl.sv
// Scoreboard bench for display_select_ctrl with short debounce/preview parameters.
module tb_display_select_ctrl;

    localparam logic [15:0] DEB  = 16'd4;
    localparam logic [23:0] PREV = 24'd8;
    localparam logic [4:0]  MAXS = 5'd18;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       KEY_Next = 1'b1;
    logic       KEY_Prev = 1'b1;
    logic       KEY_Show = 1'b1;
    logic [4:0] SW_Direct = 5'd0;
    logic       SW_DirectEn = 1'b0;
    logic [4:0] Display_Select;
    logic       Display_Enable;
    logic       Select_Changed;

    typedef struct {
        logic [4:0] sel;
        int         at;
    } exp_t;

    exp_t q[$];
    exp_t popped;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_sel = 0;

    display_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .PREVIEW_CYCLES (PREV),
        .MAX_SELECT     (MAXS)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .KEY_Next      (KEY_Next),
        .KEY_Prev      (KEY_Prev),
        .KEY_Show      (KEY_Show),
        .SW_Direct     (SW_Direct),
        .SW_DirectEn   (SW_DirectEn),
        .Display_Select(Display_Select),
        .Display_Enable(Display_Enable),
        .Select_Changed(Select_Changed)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic push_exp(input int sel, input int at);
        exp_t e;
        e.sel = 5'(sel);
        e.at  = at;
        q.push_back(e);
    endtask

    // which: 0 = Next, 1 = Prev. Updates the reference model unless direct mode is on.
    task automatic press(input int which);
        int k;
        k = cyc;
        if (which == 0) KEY_Next = 1'b0;
        else            KEY_Prev = 1'b0;
        if (!SW_DirectEn) begin
            if (which == 0) exp_sel = (exp_sel == 18) ? 0 : exp_sel + 1;
            else            exp_sel = (exp_sel == 0) ? 18 : exp_sel - 1;
            push_exp(exp_sel, k + 7);
        end
        tick(8);
        KEY_Next = 1'b1;
        KEY_Prev = 1'b1;
        tick(8);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        exp_sel = 0;
    endtask

    task automatic observe_enable(input int n, output int first, output int count);
        first = -1;
        count = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (Display_Enable) begin
                if (first < 0) first = cyc;
                count++;
            end
        end
    endtask

    // Monitor: every reported change is matched against the scoreboard queue
    always @(negedge Clock) begin
        if (!Reset) begin
            check("select_in_range", int'(Display_Select <= MAXS), 1);
            if (Select_Changed) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: got select %0d at cycle %0d, expected no change",
                             Display_Select, cyc);
                end else begin
                    popped = q.pop_front();
                    check("select_value", int'(Display_Select), int'(popped.sel));
                    check("change_cycle", cyc, popped.at);
                    check("enable_with_change", int'(Display_Enable), 1);
                end
            end
        end
    end

    initial begin
        int k;
        int kr;
        int first;
        int count;
        int idle_bad;

        // Reset and idle
        tick(3);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_select", int'(Display_Select), 0);
        check("reset_enable", int'(Display_Enable), 0);
        check("reset_changed", int'(Select_Changed), 0);
        idle_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (Display_Select != 5'd0 || Display_Enable || Select_Changed) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);
        tick(1);

        // Bounce shorter than the debounce window
        KEY_Next = 1'b0;
        tick(3);
        KEY_Next = 1'b1;
        tick(20);
        @(negedge Clock);
        check("bounce_no_step", int'(Display_Select), 0);
        tick(1);

        // Held key: single step, 9-cycle enable window, no repeat
        k = cyc;
        KEY_Next = 1'b0;
        exp_sel = 1;
        push_exp(1, k + 7);
        observe_enable(30, first, count);
        check("preview_first", first, k + 7);
        check("preview_length", count, 9);
        tick(70);
        KEY_Next = 1'b1;
        tick(10);
        @(negedge Clock);
        check("held_single_step", int'(Display_Select), 1);
        tick(1);

        // Wrap around in both directions
        do_reset();
        for (int i = 0; i < 18; i++) press(0);
        @(negedge Clock);
        check("wrap_top", int'(Display_Select), 18);
        tick(1);
        press(0);
        @(negedge Clock);
        check("wrap_to_zero", int'(Display_Select), 0);
        tick(1);
        press(1);
        @(negedge Clock);
        check("wrap_prev", int'(Display_Select), 18);
        tick(1);

        // Simultaneous Next and Prev cancel
        KEY_Next = 1'b0;
        KEY_Prev = 1'b0;
        tick(8);
        KEY_Next = 1'b1;
        KEY_Prev = 1'b1;
        tick(8);
        @(negedge Clock);
        check("simultaneous_hold", int'(Display_Select), 18);
        tick(1);

        // Direct switch load, out-of-range hold, keys ignored
        SW_Direct = 5'd9;
        SW_DirectEn = 1'b1;
        exp_sel = 9;
        push_exp(9, cyc + 2);
        tick(5);
        SW_Direct = 5'd25;
        tick(5);
        press(0);
        press(1);
        @(negedge Clock);
        check("direct_hold", int'(Display_Select), 9);
        tick(1);
        SW_DirectEn = 1'b0;
        tick(20);

        // Show key held 20 cycles
        @(negedge Clock);
        check("enable_idle_before_show", int'(Display_Enable), 0);
        tick(1);
        k = cyc;
        KEY_Show = 1'b0;
        first = -1;
        count = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Display_Enable) begin
                if (first < 0) first = cyc;
                count++;
            end
            @(posedge Clock);
            #1;
            if (cyc == k + 20) KEY_Show = 1'b1;
        end
        check("show_first", first, k + 7);
        check("show_length", count, 20);

        // Reset in the middle of a preview window with Prev held
        k = cyc;
        KEY_Prev = 1'b0;
        exp_sel = 8;
        push_exp(8, k + 7);
        tick(10);
        Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        kr = cyc;
        @(negedge Clock);
        check("midreset_select", int'(Display_Select), 0);
        check("midreset_enable", int'(Display_Enable), 0);
        check("midreset_changed", int'(Select_Changed), 0);
        exp_sel = 18;
        push_exp(18, kr + 7);
        tick(15);
        KEY_Prev = 1'b1;
        tick(10);
        @(negedge Clock);
        check("post_reset_prev", int'(Display_Select), 18);
        check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_select_ctrl.md
Name: display_select_ctrl

Overview:
- Upstream neighbour of the debug display multiplexer. Turns the board pushbuttons and switches into the registered Display_Select[4:0] and Display_Enable signals that the multiplexer consumes.
- Synchronises and debounces the active-low keys, steps a wrapping select index, and can take the index directly from switches.
- Raises Display_Enable for a timed preview window after every select change, so the multiplexer refreshes without the Show key being held.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before a key change is accepted (min 2).
- PREVIEW_CYCLES, 24'd12500000, length of the Display_Enable window after a select change (0 disables the window).
- MAX_SELECT, 5'd18, highest valid select index; the index wraps between 0 and MAX_SELECT.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- KEY_Next  input  1  active-low pushbutton, select + 1.
- KEY_Prev  input  1  active-low pushbutton, select - 1.
- KEY_Show  input  1  active-low pushbutton, force display while held.
- SW_Direct  input  5  switch-supplied select index.
- SW_DirectEn  input  1  1 = select taken from SW_Direct; keys Next/Prev ignored.
- Display_Select  output  5  registered select index to the display multiplexer.
- Display_Enable  output  1  registered enable to the display multiplexer.
- Select_Changed  output  1  one-cycle pulse when Display_Select changes.

Behaviour:
- All state updates on posedge Clock; Reset takes priority over everything.
- Reset values:
  - Display_Select = 0, Display_Enable = 0, Select_Changed = 0.
  - Synchroniser flops = 1, debounced key states = 1 (released), debounce counters = 0, preview counter = 0.
- Synchronisation: each KEY passes through a 2-flop synchroniser. SW_Direct and SW_DirectEn are sampled through one register stage.
- Debounce (per key):
  - If the synced value equals the stable state, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the value still differs, the stable state takes the synced value and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES leaves no effect.
  - Pin-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Press event: a one-cycle internal pulse on the stable 1 -> 0 transition only. Release generates nothing; a held key generates exactly one event.
- Select update, registered, visible the cycle after the event. Priority order:
  1. SW_DirectEn = 1: load SW_Direct if it is <= MAX_SELECT; otherwise hold the current value. Next/Prev events are discarded.
  2. Next and Prev events in the same cycle: no change.
  3. Next: if Display_Select == MAX_SELECT then 0, else +1.
  4. Prev: if Display_Select == 0 then MAX_SELECT, else -1.
- Select_Changed: high for exactly one cycle, in the same cycle the new Display_Select value first appears. Not raised when a load writes an identical value.
- Preview counter:
  - Loaded with PREVIEW_CYCLES in the cycle Select_Changed rises.
  - Otherwise decrements to 0 and saturates there.
  - A change during an active window reloads the counter.
- Display_Enable (registered) = debounced Show pressed OR preview counter != 0 OR Select_Changed. It therefore rises together with Select_Changed.
- Display_Enable drops one cycle after both the Show key and the preview window have ended.
- Reset mid-operation: all state returns to its reset value. A key held through reset is treated as a fresh press and yields one event after 2 + DEBOUNCE_CYCLES cycles.
- Display_Select never leaves the range 0..MAX_SELECT under any input sequence.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES = 4, PREVIEW_CYCLES = 8, MAX_SELECT = 18.
- Reset/idle: assert Reset for 3 cycles with all keys high -> Display_Select = 0, Display_Enable = 0, Select_Changed = 0; all outputs stay put for 50 idle cycles.
- Debounce: KEY_Next low for 3 cycles then high -> no change. KEY_Next held low -> Display_Select 0 -> 1 exactly 7 cycles after the falling edge, Select_Changed pulses once, Display_Enable high for 9 cycles. Holding the key 100 cycles gives no further step.
- Wrap: 18 Next presses from 0 -> Display_Select = 18. One more Next -> 0. Prev from 0 -> 18.
- Simultaneous/direct: Next and Prev falling on the same cycle -> no change, no pulse. SW_DirectEn = 1 with SW_Direct = 9 -> Display_Select = 9. SW_Direct = 25 -> holds 9. Next presses while SW_DirectEn = 1 -> ignored.
- Show key: KEY_Show held 20 cycles with no select change -> Display_Enable high from cycle 7 after the press until 1 cycle after debounced release.
- Reset mid-window: Reset asserted 3 cycles into a preview window with KEY_Prev held -> outputs at reset values. Once Reset drops, Display_Select = 18 after 7 more cycles.
